regfile_seq: RTL and testbench

Request sequencer driving the initiator side of the 32-entry, 64-bit multi-port register file (`regfile3`): 4-bit one-hot read select, single shared `out`, two write ports.
- Accepts one access request (up to 4 reads, 2 writes) over a valid/ready handshake.
- Issues the reads one per cycle on the shared output, then both writes in one cycle.
- Returns the collected read data as one response.
- Sits between the issue logic and the register file; it is the only agent driving the file's ports.

---
 rtl/regfile_seq_pkg.sv | 16 +
 rtl/regfile_seq_pick.sv | 20 ++
 rtl/regfile_seq.sv | 164 ++++++++++++++++
 tb/tb_regfile_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file request sequencer.
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD     = 4;
  localparam int NUM_WR     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_seq_pick.sv
// Lowest-set-bit picker: one-hot select and binary index of the lowest
// pending read port. Index is 0 when the mask is empty.
module regfile_seq_pick
  import regfile_seq_pkg::*;
(
  input  logic [NUM_RD-1:0] mask_i,
  output logic [NUM_RD-1:0] onehot_o,
  output logic [1:0]        idx_o
);

  // Isolate the lowest set bit; scan downwards so the lowest bit wins the index.
  always_comb begin
    onehot_o = mask_i & (~mask_i + NUM_RD'(1));
    idx_o    = 2'd0;
    for (int i = NUM_RD - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 2'(i);
    end
  end

endmodule

// File: rtl/regfile_seq.sv
// Request sequencer for the 4-read/2-write register file.
// Reads are issued one per cycle on the shared rf_out, then both writes
// in a single cycle, then the collected data is returned as one response.
// Optional feature: define REGFILE_SEQ_FWD_EN to forward same-request
// write data into the read results.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_rd_en,
  input  logic [1:0]        req_wr_en,
  input  logic [ADDR_W-1:0] req_rd_addr1,
  input  logic [ADDR_W-1:0] req_rd_addr2,
  input  logic [ADDR_W-1:0] req_rd_addr3,
  input  logic [ADDR_W-1:0] req_rd_addr4,
  input  logic [ADDR_W-1:0] req_wr_addr1,
  input  logic [ADDR_W-1:0] req_wr_addr2,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [DATA_W-1:0] req_wdata2,
  output logic [3:0]        rf_read,
  output logic [1:0]        rf_write,
  output logic [ADDR_W-1:0] rf_read_port_1,
  output logic [ADDR_W-1:0] rf_read_port_2,
  output logic [ADDR_W-1:0] rf_read_port_3,
  output logic [ADDR_W-1:0] rf_read_port_4,
  output logic [ADDR_W-1:0] rf_write_port_1,
  output logic [ADDR_W-1:0] rf_write_port_2,
  output logic [DATA_W-1:0] rf_in1,
  output logic [DATA_W-1:0] rf_in2,
  input  logic [DATA_W-1:0] rf_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_mask,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [DATA_W-1:0] rsp_data3,
  output logic [DATA_W-1:0] rsp_data4
);

  state_e                           state_q, state_d;
  logic [NUM_RD-1:0]                pend_q, pend_d;
  logic [NUM_RD-1:0]                mask_q;
  logic [NUM_WR-1:0]                wr_en_q;
  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr_q;
  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr_q;
  logic [NUM_WR-1:0][DATA_W-1:0]    wdata_q;
  logic [NUM_RD-1:0][DATA_W-1:0]    rdata_q;

  logic [NUM_RD-1:0] pick_oh;
  logic [1:0]        pick_idx;
  logic              accept;
  logic [NUM_WR-1:0] wr_issue;
  logic [DATA_W-1:0] cap_data;

  regfile_seq_pick u_pick (
    .mask_i   (pend_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Same-address double write collapses to write 2 alone, so the later
  // write deterministically wins regardless of the file's port priority.
  assign wr_issue = ((wr_en_q == 2'b11) && (wr_addr_q[0] == wr_addr_q[1])) ?
                    2'b10 : wr_en_q;

`ifdef REGFILE_SEQ_FWD_EN
  // Read capture value: a matching enabled write of this request overrides
  // rf_out, with write 2 taking priority over write 1.
  always_comb begin
    cap_data = rf_out;
    if (wr_en_q[0] && (rd_addr_q[pick_idx] == wr_addr_q[0])) cap_data = wdata_q[0];
    if (wr_en_q[1] && (rd_addr_q[pick_idx] == wr_addr_q[1])) cap_data = wdata_q[1];
  end
`else
  // Read capture value: reads always see the file's pre-write contents.
  always_comb begin
    cap_data = rf_out;
  end
`endif

  // Next-state and handshake/port outputs.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    rf_read   = '0;
    rf_write  = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pend_d = req_rd_en;
          if (|req_rd_en)      state_d = ST_READ;
          else if (|req_wr_en) state_d = ST_WRITE;
          else                 state_d = ST_RESP;
        end
      end
      ST_READ: begin
        rf_read = pick_oh;
        pend_d  = pend_q & ~pick_oh;
        if (pend_d == '0) state_d = (|wr_en_q) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        rf_write = wr_issue;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch and read-data capture; reset drops any pending work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      wr_en_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        mask_q    <= req_rd_en;
        wr_en_q   <= req_wr_en;
        rd_addr_q <= {req_rd_addr4, req_rd_addr3, req_rd_addr2, req_rd_addr1};
        wr_addr_q <= {req_wr_addr2, req_wr_addr1};
        wdata_q   <= {req_wdata2, req_wdata1};
        rdata_q   <= '0;
      end else if (state_q == ST_READ) begin
        rdata_q[pick_idx] <= cap_data;
      end
    end
  end

  assign rf_read_port_1  = rd_addr_q[0];
  assign rf_read_port_2  = rd_addr_q[1];
  assign rf_read_port_3  = rd_addr_q[2];
  assign rf_read_port_4  = rd_addr_q[3];
  assign rf_write_port_1 = wr_addr_q[0];
  assign rf_write_port_2 = wr_addr_q[1];
  assign rf_in1          = wdata_q[0];
  assign rf_in2          = wdata_q[1];
  assign rsp_mask        = mask_q;
  assign rsp_data1       = rdata_q[0];
  assign rsp_data2       = rdata_q[1];
  assign rsp_data3       = rdata_q[2];
  assign rsp_data4       = rdata_q[3];

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq with a behavioural register file and
// a response scoreboard fed from a shadow copy of the file contents.
module tb_regfile_seq;
  import regfile_seq_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct {
    logic [3:0]         mask;
    logic [3:0][DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]    req_rd_en, rf_read, rsp_mask;
  logic [1:0]    req_wr_en, rf_write;
  logic [AW-1:0] req_rd_addr1, req_rd_addr2, req_rd_addr3, req_rd_addr4;
  logic [AW-1:0] req_wr_addr1, req_wr_addr2;
  logic [DW-1:0] req_wdata1, req_wdata2;
  logic [AW-1:0] rf_read_port_1, rf_read_port_2, rf_read_port_3, rf_read_port_4;
  logic [AW-1:0] rf_write_port_1, rf_write_port_2;
  logic [DW-1:0] rf_in1, rf_in2, rf_out;
  logic [DW-1:0] rsp_data1, rsp_data2, rsp_data3, rsp_data4;

  regfile_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_rd_addr1(req_rd_addr1), .req_rd_addr2(req_rd_addr2),
    .req_rd_addr3(req_rd_addr3), .req_rd_addr4(req_rd_addr4),
    .req_wr_addr1(req_wr_addr1), .req_wr_addr2(req_wr_addr2),
    .req_wdata1(req_wdata1), .req_wdata2(req_wdata2),
    .rf_read(rf_read), .rf_write(rf_write),
    .rf_read_port_1(rf_read_port_1), .rf_read_port_2(rf_read_port_2),
    .rf_read_port_3(rf_read_port_3), .rf_read_port_4(rf_read_port_4),
    .rf_write_port_1(rf_write_port_1), .rf_write_port_2(rf_write_port_2),
    .rf_in1(rf_in1), .rf_in2(rf_in2), .rf_out(rf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rsp_data3(rsp_data3), .rsp_data4(rsp_data4)
  );

  // Behavioural register file driven by the DUT, plus the bench's shadow.
  logic [DW-1:0] mem     [32];
  logic [DW-1:0] exp_mem [32];
  rsp_t          sb [$];
  int            checks = 0;
  int            failures = 0;

  always_comb begin
    rf_out = '0;
    case (rf_read)
      4'b0001: rf_out = mem[rf_read_port_1];
      4'b0010: rf_out = mem[rf_read_port_2];
      4'b0100: rf_out = mem[rf_read_port_3];
      4'b1000: rf_out = mem[rf_read_port_4];
      default: rf_out = '0;
    endcase
  end

  always @(posedge clk) begin
    if (rf_write[0]) mem[rf_write_port_1] <= rf_in1;
    if (rf_write[1]) mem[rf_write_port_2] <= rf_in2;
  end

  function automatic logic [3:0][DW-1:0] got_data();
    return {rsp_data4, rsp_data3, rsp_data2, rsp_data1};
  endfunction

  // Full request: drives at a negedge, checks each cycle, scoreboards the response.
  task automatic run_req(input logic [3:0] rd_en, input logic [3:0][AW-1:0] ra,
                         input logic [1:0] wr_en, input logic [1:0][AW-1:0] wa,
                         input logic [1:0][DW-1:0] wd, input int hold);
    rsp_t e, g;
    logic [1:0] wexp;
    e.mask = rd_en;
    e.data = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd_en[i]) begin
        e.data[i] = exp_mem[ra[i]];
`ifdef REGFILE_SEQ_FWD_EN
        if (wr_en[0] && ra[i] == wa[0]) e.data[i] = wd[0];
        if (wr_en[1] && ra[i] == wa[1]) e.data[i] = wd[1];
`endif
      end
    end
    wexp = (wr_en == 2'b11 && wa[0] == wa[1]) ? 2'b10 : wr_en;
    if (wexp[0]) exp_mem[wa[0]] = wd[0];
    if (wexp[1]) exp_mem[wa[1]] = wd[1];

    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL req_ready_idle got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_rd_en = rd_en; req_wr_en = wr_en;
    req_rd_addr1 = ra[0]; req_rd_addr2 = ra[1]; req_rd_addr3 = ra[2]; req_rd_addr4 = ra[3];
    req_wr_addr1 = wa[0]; req_wr_addr2 = wa[1]; req_wdata1 = wd[0]; req_wdata2 = wd[1];
    rsp_ready = 1'b0;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_rd_en = '0; req_wr_en = '0; req_wdata1 = '1; req_wdata2 = '1;
    for (int i = 0; i < 4; i++) begin
      if (rd_en[i]) begin
        checks++;
        if (rf_read !== 4'(1 << i) || rf_write !== 2'b00 || rsp_valid !== 1'b0) begin
          failures++;
          $display("FAIL read_cycle%0d got rf_read=%b rf_write=%b rsp_valid=%b want rf_read=%b 00 0",
                   i, rf_read, rf_write, rsp_valid, 4'(1 << i));
        end
        @(negedge clk);
      end
    end
    if (wr_en != 2'b00) begin
      checks++;
      if (rf_write !== wexp || rf_read !== 4'b0000 || rsp_valid !== 1'b0 ||
          (wexp[0] && (rf_write_port_1 !== wa[0] || rf_in1 !== wd[0])) ||
          (wexp[1] && (rf_write_port_2 !== wa[1] || rf_in2 !== wd[1]))) begin
        failures++;
        $display("FAIL write_cycle got rf_write=%b a1=%0d d1=%h a2=%0d d2=%h want %b a1=%0d d1=%h a2=%0d d2=%h",
                 rf_write, rf_write_port_1, rf_in1, rf_write_port_2, rf_in2,
                 wexp, wa[0], wd[0], wa[1], wd[1]);
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL scoreboard_empty got=0 want=1 entry");
    end else begin
      g = sb.pop_front();
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_mask !== g.mask || got_data() !== g.data) begin
        failures++;
        $display("FAIL response got v=%b rdy=%b mask=%b data=%h want v=1 rdy=0 mask=%b data=%h",
                 rsp_valid, req_ready, rsp_mask, got_data(), g.mask, g.data);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_mask !== g.mask || got_data() !== g.data) begin
          failures++;
          $display("FAIL response_hold%0d got v=%b rdy=%b mask=%b data=%h want v=1 rdy=0 mask=%b data=%h",
                   h, rsp_valid, req_ready, rsp_mask, got_data(), g.mask, g.data);
        end
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rsp_release got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (rf_read !== 4'b0 || rf_write !== 2'b0 || rsp_valid !== 1'b0 || rsp_mask !== 4'b0 ||
        got_data() !== '0 || rf_read_port_1 !== '0 || rf_read_port_4 !== '0 ||
        rf_write_port_1 !== '0 || rf_write_port_2 !== '0 || rf_in1 !== '0 || rf_in2 !== '0) begin
      failures++;
      $display("FAIL %s got rd=%b wr=%b v=%b mask=%b data=%h in1=%h want all zero",
               tag, rf_read, rf_write, rsp_valid, rsp_mask, got_data(), rf_in1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_outputs");
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_in_rst got=%b want=0", req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after got=%b want=1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_four_reads();
    run_req(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 2'b00, '0, '0, 0);
  endtask

  task automatic test_read_write();
    logic [DW-1:0] want;
`ifdef REGFILE_SEQ_FWD_EN
    want = 64'hA;
`else
    want = 64'h7777;
`endif
    checks++;
    if (exp_mem[7] !== 64'h7777) begin
      failures++; $display("FAIL shadow_reg7 got=%h want=7777", exp_mem[7]);
    end
    run_req(4'b0101, {5'd0, 5'd9, 5'd0, 5'd7}, 2'b11, {5'd8, 5'd7}, {64'hB, 64'hA}, 1);
    // response has been released; the registered data stays latched
    checks++;
    if (rsp_data1 !== want || rsp_data2 !== '0 || rsp_data3 !== 64'h9999 || rsp_data4 !== '0) begin
      failures++;
      $display("FAIL rw_data got d1=%h d2=%h d3=%h d4=%h want %h 0 9999 0",
               rsp_data1, rsp_data2, rsp_data3, rsp_data4, want);
    end
  endtask

  task automatic test_dup_write();
    run_req(4'b0000, '0, 2'b11, {5'd5, 5'd5}, {64'h2, 64'h1}, 0);
    run_req(4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, 2'b00, '0, '0, 0);
    checks++;
    if (rsp_data2 !== 64'h2) begin
      failures++; $display("FAIL dup_write_readback got=%h want=2", rsp_data2);
    end
  endtask

  task automatic test_empty();
    run_req(4'b0000, '0, 2'b00, '0, '0, 3);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_rd_en = 4'b1111; req_wr_en = 2'b01;
    req_rd_addr1 = 5'd1; req_rd_addr2 = 5'd2; req_rd_addr3 = 5'd3; req_rd_addr4 = 5'd4;
    req_wr_addr1 = 5'd10; req_wdata1 = 64'hDEAD;
    @(negedge clk);
    req_valid = 1'b0; req_wr_en = '0;
    checks++;
    if (rf_read !== 4'b0001) begin
      failures++; $display("FAIL midrst_first_read got=%b want=0001", rf_read);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst_outputs");
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_ready got=%b want=1", req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rf_write !== 2'b00 || rf_read !== 4'b0000) begin
        failures++; $display("FAIL midrst_idle%0d got wr=%b rd=%b want 00 0000", c, rf_write, rf_read);
      end
    end
    // reg 10 keeps its preload value since the aborted write never issued
    run_req(4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, 2'b00, '0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0][AW-1:0] ra;
    logic [1:0][AW-1:0] wa;
    logic [1:0][DW-1:0] wd;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) ra[i] = AW'($urandom_range(0, 31));
      for (int j = 0; j < 2; j++) begin
        wa[j] = AW'($urandom_range(0, 31));
        wd[j] = {$urandom, $urandom};
      end
      run_req(4'($urandom_range(0, 15)), ra, 2'($urandom_range(0, 3)), wa, wd, t % 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 64'(i) * 64'h1111;
      exp_mem[i] = 64'(i) * 64'h1111;
    end
    req_valid = 0; req_rd_en = 0; req_wr_en = 0; rsp_ready = 0;
    req_rd_addr1 = 0; req_rd_addr2 = 0; req_rd_addr3 = 0; req_rd_addr4 = 0;
    req_wr_addr1 = 0; req_wr_addr2 = 0; req_wdata1 = 0; req_wdata2 = 0;
    @(negedge clk);
    test_reset();
    test_four_reads();
    test_read_write();
    test_dup_write();
    test_empty();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
